// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the instruction-decode stage.
//   - default field widths
//   - field bit positions for the default instruction layout
//   - decoded-field struct at the default widths
//   - field_lsb(): LSB of a register-address field, used by parametrised users
//   - extend(): sign/zero extension of an operand field up to 64 bits
// Fields are packed from the MSB: opcode, src1, src2, dest, then any spare
// low bits that only appear inside the operand.
package decode_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_RA_W    = 4;
  localparam int DEF_DATA_W  = 16;

  // idx 1 = src1, 2 = src2, 3 = dest
  function automatic int field_lsb(input int instr_w, input int op_w,
                                   input int ra_w, input int idx);
    return instr_w - op_w - idx * ra_w;
  endfunction

  localparam int DEF_OPND_W   = DEF_INSTR_W - DEF_OP_W;
  localparam int DEF_OP_LSB   = DEF_INSTR_W - DEF_OP_W;
  localparam int DEF_SRC1_LSB = field_lsb(DEF_INSTR_W, DEF_OP_W, DEF_RA_W, 1);
  localparam int DEF_SRC2_LSB = field_lsb(DEF_INSTR_W, DEF_OP_W, DEF_RA_W, 2);
  localparam int DEF_DEST_LSB = field_lsb(DEF_INSTR_W, DEF_OP_W, DEF_RA_W, 3);

  typedef struct packed {
    logic [DEF_OP_W-1:0]   opcode;
    logic [DEF_RA_W-1:0]   src1;
    logic [DEF_RA_W-1:0]   src2;
    logic [DEF_RA_W-1:0]   dest;
    logic [DEF_OPND_W-1:0] operand;
    logic                  illegal;
  } dec_fields_t;

  // Keeps the low 'width' bits of value; the bits above are filled with the
  // operand's top bit when sext is set, zero otherwise. width is 1..63.
  function automatic logic [63:0] extend(input logic [63:0] value,
                                         input int width,
                                         input logic sext);
    logic [63:0] keep;
    logic        fill;
    keep = (64'd1 << width) - 64'd1;
    fill = sext & (|(value & (64'd1 << (width - 1))));
    return (value & keep) | (fill ? ~keep : 64'd0);
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and downstream-side signals of the decode stage.
//   master: the surroundings (fetch drives instruction/in_valid/flush,
//           downstream drives out_ready and consumes the decoded fields)
//   slave : the decode stage itself
interface decode_if
  import decode_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int RA_W    = DEF_RA_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = 8
);
  localparam int OPND_W = INSTR_W - OP_W;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    opcode;
  logic [RA_W-1:0]    src_addr1;
  logic [RA_W-1:0]    src_addr2;
  logic [RA_W-1:0]    dest_addr;
  logic [OPND_W-1:0]  operand;
  logic [DATA_W-1:0]  imm_ext;
  logic               illegal;
  logic [CNT_W-1:0]   illegal_cnt;

  modport master (
    output flush, in_valid, instruction, out_ready,
    input  in_ready, out_valid, opcode, src_addr1, src_addr2, dest_addr,
           operand, imm_ext, illegal, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, instruction, out_ready,
    output in_ready, out_valid, opcode, src_addr1, src_addr2, dest_addr,
           operand, imm_ext, illegal, illegal_cnt
  );

endinterface

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: generic 2-entry valid/ready buffer.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of both entries (wins over all)
//   in_valid/in_ready   upstream handshake; in_ready = skid entry empty
//   in_data [W]         payload in
//   out_valid/out_ready downstream handshake, driven from the main entry
//   out_data [W]        payload out (main entry register)
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to in_ready.
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld_p1;
  logic         skid_vld_p1;
  logic [W-1:0] main_p1;
  logic [W-1:0] skid_p1;
  logic         accept;
  logic         main_free;

  assign accept    = in_valid & in_ready;
  // main can take a new word when it is empty or handing its word off now
  assign main_free = ~main_vld_p1 | out_ready;

  // ---- stage p1: main + skid entries ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (main_free) begin
      if (skid_vld_p1) begin
        main_vld_p1 <= 1'b1;
        main_p1     <= skid_p1;
        skid_vld_p1 <= accept;
        if (accept) skid_p1 <= in_data;
      end else begin
        main_vld_p1 <= accept;
        if (accept) main_p1 <= in_data;
      end
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
      skid_p1     <= in_data;
    end
  end

  assign in_ready  = ~skid_vld_p1;
  assign out_valid = main_vld_p1;
  assign out_data  = main_p1;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode pipeline stage.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    decode_if.slave:
//            flush, in_valid, instruction, out_ready   (in)
//            in_ready, out_valid, opcode, src_addr1, src_addr2, dest_addr,
//            operand, imm_ext, illegal, illegal_cnt    (out)
// The incoming word is split combinationally, the result (including the
// extended immediate and the illegal flag) is captured by the skid buffer,
// and every output comes from the buffer's registered main entry.
// illegal_cnt counts delivered illegal words, saturating; flush leaves it.
module decode_stage
  import decode_pkg::*;
#(
  parameter int                INSTR_W      = DEF_INSTR_W,
  parameter int                OP_W         = DEF_OP_W,
  parameter int                RA_W         = DEF_RA_W,
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                SEXT_IMM     = 1,
  parameter logic [2**OP_W-1:0] ILLEGAL_MASK = '0,
  parameter int                CNT_W        = 8
) (
  input logic      clk,
  input logic      rst_n,
  decode_if.slave  bus
);

  localparam int OPND_W   = INSTR_W - OP_W;
  localparam int SRC1_LSB = field_lsb(INSTR_W, OP_W, RA_W, 1);
  localparam int SRC2_LSB = field_lsb(INSTR_W, OP_W, RA_W, 2);
  localparam int DEST_LSB = field_lsb(INSTR_W, OP_W, RA_W, 3);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [RA_W-1:0]   src1;
    logic [RA_W-1:0]   src2;
    logic [RA_W-1:0]   dest;
    logic [OPND_W-1:0] operand;
    logic [DATA_W-1:0] imm;
    logic              illegal;
  } fields_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fields_t          dec_p0;
  fields_t          out_p1;
  logic             vld_p1;
  logic             deliver;
  logic [CNT_W-1:0] cnt_p1;

  // ---- stage p0: combinational field split of the incoming word ----
  always_comb begin
    dec_p0         = '0;
    dec_p0.opcode  = bus.instruction[INSTR_W-1 -: OP_W];
    dec_p0.src1    = bus.instruction[SRC1_LSB +: RA_W];
    dec_p0.src2    = bus.instruction[SRC2_LSB +: RA_W];
    dec_p0.dest    = bus.instruction[DEST_LSB +: RA_W];
    dec_p0.operand = bus.instruction[OPND_W-1:0];
    dec_p0.imm     = DATA_W'(extend(64'(bus.instruction[OPND_W-1:0]),
                                    OPND_W, SEXT_IMM != 0));
    dec_p0.illegal = ILLEGAL_MASK[dec_p0.opcode];
  end

  // ---- stage p1: registered main/skid entries ----
  decode_skid_buf #(
    .W ($bits(fields_t))
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec_p0),
    .out_valid (vld_p1),
    .out_ready (bus.out_ready),
    .out_data  (out_p1)
  );

  assign deliver = vld_p1 & bus.out_ready;

  // a delivery coinciding with flush is discarded, so it is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (!bus.flush && deliver && out_p1.illegal) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.opcode      = out_p1.opcode;
  assign bus.src_addr1   = out_p1.src1;
  assign bus.src_addr2   = out_p1.src2;
  assign bus.dest_addr   = out_p1.dest;
  assign bus.operand     = out_p1.operand;
  assign bus.imm_ext     = out_p1.imm;
  assign bus.illegal     = out_p1.illegal;
  assign bus.illegal_cnt = cnt_p1;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage.
// dut_a: sign-extending, opcode 15 illegal, 2-bit counter (main checks).
// dut_b: zero-extending defaults (imm_ext extension check).
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  d;
    logic [11:0] opnd;
    logic [15:0] imm;
    logic        ill;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] exp_cnt;
  logic       last_acc;

  decode_if #(.INSTR_W(16), .OP_W(4), .RA_W(4), .DATA_W(16), .CNT_W(2)) ifa ();
  decode_if #(.INSTR_W(16), .OP_W(4), .RA_W(4), .DATA_W(16), .CNT_W(8)) ifb ();

  decode_stage #(
    .INSTR_W(16), .OP_W(4), .RA_W(4), .DATA_W(16),
    .SEXT_IMM(1), .ILLEGAL_MASK(16'h8000), .CNT_W(2)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  decode_stage #(
    .INSTR_W(16), .OP_W(4), .RA_W(4), .DATA_W(16),
    .SEXT_IMM(0), .ILLEGAL_MASK(16'h0000), .CNT_W(8)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    e.op   = ins[15:12];
    e.s1   = ins[11:8];
    e.s2   = ins[7:4];
    e.d    = ins[3:0];
    e.opnd = ins[11:0];
    e.imm  = {{4{ins[11]}}, ins[11:0]};
    e.ill  = (ins[15:12] == 4'hF);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; samples
  // dut_a, updates the scoreboard, then advances one full clock.
  task automatic step();
    exp_t e;
    logic acc;
    logic dlv;
    #1;
    acc = ifa.in_valid & ifa.in_ready;
    dlv = ifa.out_valid & ifa.out_ready;
    chk("illegal_cnt", 32'(ifa.illegal_cnt), 32'(exp_cnt));
    if (ifa.out_valid === 1'b1) begin
      chk("out_valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb[0];
        chk("opcode",    32'(ifa.opcode),    32'(e.op));
        chk("src_addr1", 32'(ifa.src_addr1), 32'(e.s1));
        chk("src_addr2", 32'(ifa.src_addr2), 32'(e.s2));
        chk("dest_addr", 32'(ifa.dest_addr), 32'(e.d));
        chk("operand",   32'(ifa.operand),   32'(e.opnd));
        chk("imm_ext",   32'(ifa.imm_ext),   32'(e.imm));
        chk("illegal",   32'(ifa.illegal),   32'(e.ill));
      end
    end
    if (ifa.flush) begin
      sb.delete();
    end else begin
      if (dlv && sb.size() > 0) begin
        e = sb.pop_front();
        if (e.ill && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      end
      if (acc) sb.push_back(model(ifa.instruction));
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic accepted;
    total = 0;
    bad = 0;
    exp_cnt = 2'd0;
    last_acc = 1'b0;
    rst_n = 1'b0;
    ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.instruction = 16'h0; ifa.out_ready = 1'b0;
    ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.instruction = 16'h0; ifb.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset state
    chk("rst_out_valid",   32'(ifa.out_valid),   32'd0);
    chk("rst_opcode",      32'(ifa.opcode),      32'd0);
    chk("rst_operand",     32'(ifa.operand),     32'd0);
    chk("rst_imm_ext",     32'(ifa.imm_ext),     32'd0);
    chk("rst_illegal",     32'(ifa.illegal),     32'd0);
    chk("rst_illegal_cnt", 32'(ifa.illegal_cnt), 32'd0);
    chk("rst_b_out_valid", 32'(ifb.out_valid),   32'd0);
    rst_n = 1'b1;
    step();
    chk("in_ready_after_reset", 32'(ifa.in_ready), 32'd1);

    // basic decode, one-cycle latency
    ifa.in_valid = 1'b1; ifa.instruction = 16'h1234; ifa.out_ready = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    chk("basic_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("basic_opcode",    32'(ifa.opcode),    32'd1);
    chk("basic_src1",      32'(ifa.src_addr1), 32'd2);
    chk("basic_src2",      32'(ifa.src_addr2), 32'd3);
    chk("basic_dest",      32'(ifa.dest_addr), 32'd4);
    chk("basic_operand",   32'(ifa.operand),   32'h234);
    chk("basic_imm",       32'(ifa.imm_ext),   32'h0234);
    chk("basic_illegal",   32'(ifa.illegal),   32'd0);
    step();

    // sign extension (dut_a) and zero extension (dut_b)
    ifa.in_valid = 1'b1; ifa.instruction = 16'h5F00;
    step();
    ifa.in_valid = 1'b0;
    chk("sext_imm", 32'(ifa.imm_ext), 32'hFF00);
    step();
    ifb.in_valid = 1'b1; ifb.instruction = 16'h5F00; ifb.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifb.in_valid = 1'b0;
    chk("zext_out_valid", 32'(ifb.out_valid), 32'd1);
    chk("zext_imm",       32'(ifb.imm_ext),   32'h0F00);

    // backpressure: first word held, second in skid, third waits
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.instruction = 16'h1001;
    step();
    ifa.instruction = 16'h2002;
    step();
    ifa.instruction = 16'h3003;
    step();
    chk("bp_in_ready",  32'(ifa.in_ready),  32'd0);
    chk("bp_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("bp_held_op",   32'(ifa.operand),   32'h001);
    step();
    ifa.out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 6 && !accepted; i++) begin
      step();
      if (last_acc) accepted = 1'b1;
    end
    chk("bp_third_accepted", 32'(accepted), 32'd1);
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // flush with both entries full and a same-cycle input handshake
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.instruction = 16'hF111;
    step();
    ifa.instruction = 16'hF222;
    step();
    chk("fl_full_in_ready", 32'(ifa.in_ready), 32'd0);
    ifa.flush = 1'b1; ifa.instruction = 16'hF0F0; ifa.out_ready = 1'b1;
    step();
    ifa.flush = 1'b0; ifa.in_valid = 1'b0;
    chk("fl_out_valid",   32'(ifa.out_valid),   32'd0);
    chk("fl_in_ready",    32'(ifa.in_ready),    32'd1);
    chk("fl_illegal_cnt", 32'(ifa.illegal_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step();

    // illegal counting and saturation (2-bit counter)
    ifa.in_valid = 1'b1; ifa.instruction = 16'hF000; ifa.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ifa.in_valid = 1'b0;
    step();
    step();
    chk("ill_sat_cnt", 32'(ifa.illegal_cnt), 32'd3);

    // asynchronous reset mid-stream
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.instruction = 16'h1234;
    step();
    ifa.instruction = 16'h4321;
    step();
    ifa.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ifa.out_valid),   32'd0);
    chk("arst_opcode",    32'(ifa.opcode),      32'd0);
    chk("arst_src1",      32'(ifa.src_addr1),   32'd0);
    chk("arst_dest",      32'(ifa.dest_addr),   32'd0);
    chk("arst_operand",   32'(ifa.operand),     32'd0);
    chk("arst_imm",       32'(ifa.imm_ext),     32'd0);
    chk("arst_illegal",   32'(ifa.illegal),     32'd0);
    chk("arst_cnt",       32'(ifa.illegal_cnt), 32'd0);
    sb.delete();
    exp_cnt = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    ifa.in_valid = 1'b1; ifa.instruction = 16'h1234; ifa.out_ready = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    chk("post_rst_valid",  32'(ifa.out_valid), 32'd1);
    chk("post_rst_opcode", 32'(ifa.opcode),    32'd1);
    chk("post_rst_imm",    32'(ifa.imm_ext),   32'h0234);
    step();

    // final drain, bounded
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() > 0; i++) step();
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage. Sits between the fetch stage and the register-file/ALU stage.
- Splits an instruction into opcode, two source register addresses, a destination register address and an operand field.
- Adds a valid/ready handshake with a 2-entry skid buffer, immediate extension, illegal-opcode flagging, flush and a saturating illegal-instruction counter.

Parameters:
INSTR_W, 16, instruction width; must satisfy INSTR_W >= OP_W + 3*RA_W
OP_W, 4, opcode field width
RA_W, 4, register-address field width
DATA_W, 16, width of extended immediate; must satisfy DATA_W >= INSTR_W-OP_W
SEXT_IMM, 1, 1 = sign-extend operand into imm_ext, 0 = zero-extend
ILLEGAL_MASK, 0 (width 2**OP_W), bit k set = opcode k is illegal
CNT_W, 8, illegal-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  instruction valid from fetch
in_ready  out  1  stage can accept an instruction
instruction  in  INSTR_W  raw instruction
out_valid  out  1  decoded fields valid
out_ready  in  1  downstream accepts
opcode  out  OP_W  instruction[INSTR_W-1 -: OP_W]
src_addr1  out  RA_W  next RA_W bits below opcode
src_addr2  out  RA_W  next RA_W bits below src_addr1
dest_addr  out  RA_W  next RA_W bits below src_addr2
operand  out  INSTR_W-OP_W  instruction[INSTR_W-OP_W-1:0], raw
imm_ext  out  DATA_W  operand extended per SEXT_IMM
illegal  out  1  ILLEGAL_MASK[opcode]
illegal_cnt  out  CNT_W  count of illegal instructions delivered

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0; all field outputs, imm_ext and illegal = 0; illegal_cnt=0. Both buffer entries are empty, and in_ready=1 from the first edge after reset release.
- Field packing: fields are packed from the MSB. Bits below dest_addr, when INSTR_W > OP_W+3*RA_W, appear only in operand and imm_ext.
- Decode logic: combinational on the incoming word. Results are captured into the buffer; outputs always come from the registered main entry.
- Handshake: accept when in_valid & in_ready. Deliver when out_valid & out_ready.
- Buffer: main entry (drives outputs) plus skid entry.
- in_ready = !skid_full, registered, so it has no combinational path from out_ready.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N (one cycle). Full throughput of 1 per cycle when out_ready is held at 1.
- Main empty, or main delivering: the accepted word goes to main. If skid holds a word, skid moves to main and the new word goes to skid.
- Main stalled (out_valid & !out_ready): the accepted word goes to skid, and in_ready drops the next cycle.
- Skid full and main delivers: skid moves to main, in_ready returns to 1 the next cycle.
- Outputs hold stable while out_valid & !out_ready.
- illegal_cnt: increments by 1 on each delivery with illegal=1. Saturates at all-ones and does not wrap. Not cleared by flush.
- flush (synchronous, highest priority): at the edge, both entries are emptied and out_valid=0. A same-cycle input handshake is discarded, and a same-cycle delivery is not counted. in_ready=1 on the following cycle.
- Reset mid-operation: both entries are emptied immediately and asynchronously, all outputs go to reset values, and in-flight words are lost.
- in_valid=0: no state change except deliveries.

Decomposition:
- Package decode_pkg holds:
  - default widths (INSTR_W, OP_W, RA_W, DATA_W);
  - localparams for field bit positions;
  - a struct of decoded fields (opcode, src1, src2, dest, operand, illegal);
  - an extend function.
- One sub-module, decode_skid_buf: a generic 2-entry valid/ready buffer of parametrised payload width, carrying the packed decoded struct.
- decode_stage instantiates the decode logic, decode_skid_buf and the counter.

Test Plan:
- Reset then in_valid=1, instruction=16'h1234, out_ready=1 → after 1 cycle: out_valid=1, opcode=1, src_addr1=2, src_addr2=3, dest_addr=4, operand=12'h234, imm_ext=16'h0234, illegal=0.
- SEXT_IMM=1, instruction=16'h5F00 → imm_ext=16'hFF00. With SEXT_IMM=0 → imm_ext=16'h0F00.
- Backpressure: stream 16'h1001,16'h2002,16'h3003 with out_ready=0 → first word held on outputs, second in skid, in_ready=0. Raise out_ready → all three delivered in order with no loss or duplication.
- ILLEGAL_MASK=16'h8000, CNT_W=2, deliver five 16'hF000 → illegal=1 on each, illegal_cnt sequence 1,2,3,3,3.
- Buffer holding two words, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, illegal_cnt unchanged, no flushed word ever delivered.
- Drop rst_n mid-stream, asynchronously between edges → out_valid=0 and all outputs zero immediately. After release, 16'h1234 decodes correctly.
